ahb_lite_decoder_mux: RTL and testbench
=======================================

# ahb_lite_decoder_mux

AHB-Lite address decoder and slave-side multiplexer sitting between the Cortex-M0 master port and up to four AHB-Lite slaves. Slave 0 is the on-chip code/data memory. It decodes each address phase into one-hot slave selects, registers the selection for the data phase, and steers HRDATA, HREADY and HRESP back to the master. It also contains a built-in default slave that answers transfers to unmapped addresses.

## Interface
- S0_BASE, 32'h0000_0000, slave 0 base (code/data memory)
- S0_MASK, 32'hFFFF_8000, slave 0 compare mask (32 KB window)
- S1_BASE / S1_MASK, 32'h5000_0000 / 32'hFF00_0000, slave 1 window
- S2_BASE / S2_MASK, 32'h5100_0000 / 32'hFF00_0000, slave 2 window
- S3_BASE / S3_MASK, 32'h5200_0000 / 32'hFF00_0000, slave 3 window
- HCLK  in  1  bus clock
- HRESET  in  1  asynchronous, active-high reset
- HADDR  in  32  master address
- HTRANS  in  2  master transfer type
- HSEL_S  out  4  one-hot slave selects, combinational from HADDR
- HREADYOUT_S  in  4  per-slave ready, bit n from slave n
- HRESP_S  in  4  per-slave response, bit n from slave n (tie 0 for slaves without HRESP)
- HRDATA_S0 .. HRDATA_S3  in  32 each  per-slave read data
- HREADY  out  1  muxed ready to master and fanned back to all slaves
- HRESP  out  1  muxed response to master (0 OKAY, 1 ERROR)
- HRDATA  out  32  muxed read data to master

## Operation
- Decode: slave n is hit when (HADDR & Sn_MASK) == Sn_BASE. On overlapping hits, the lowest index wins. HSEL_S is asserted for any HTRANS, including IDLE, and is at most one-hot. No hit selects the default slave, which is internal and has no select output.
- Data-phase select register `dsel` (3 bits: S0..S3 or DEF):
  - Loads the decoded slave on every rising HCLK where HREADY=1.
  - Holds its value while HREADY=0.
  - Reset value: DEF.
- Output mux:
  - dsel = Sn: HREADY, HRESP and HRDATA come from slave n.
  - dsel = DEF: HRDATA = 0, and HREADY/HRESP come from the default-slave FSM.
- Default-slave FSM, states IDLE, ERR1, ERR2:
  - IDLE: HREADY=1, HRESP=0. Moves to ERR1 when HREADY=1, the decode misses, and HTRANS[1]=1 (NONSEQ or SEQ).
  - ERR1: HREADY=0, HRESP=1. Always moves to ERR2.
  - ERR2: HREADY=1, HRESP=1. Moves to ERR1 if the address phase presented now is another unmapped NONSEQ/SEQ. Otherwise moves to IDLE.
  - IDLE or BUSY transfers to unmapped addresses get a zero-wait OKAY.
- Reset asserted mid-transfer forces dsel=DEF and FSM=IDLE immediately. HREADY=1, HRESP=0 and HRDATA=0 while HRESET=1.

## Timing
- Decode is combinational: HSEL_S is valid in the same cycle as HADDR.
- Response path is combinational from the slave inputs through the dsel mux; the muxes add no wait states.
- A mapped slave's wait states propagate unchanged. dsel stays stable for the whole stretched data phase.
- Unmapped NONSEQ/SEQ costs exactly 2 data-phase cycles (ERR1, then ERR2).
- The master's new address phase is accepted only in the cycle HREADY=1. Back-to-back transfers to different slaves switch dsel on that same edge.

## Configuration
- AHB_DECODER_ERR_EN
  - Defined: the default slave behaves as above, giving a two-cycle ERROR on unmapped NONSEQ/SEQ.
  - Undefined: the FSM is not built, and every unmapped transfer completes zero-wait with HRESP=0 and HRDATA=0.

## Test plan
- Reset: assert HRESET mid-read from S1 -> HREADY=1, HRESP=0, HRDATA=0 at once; after release the first transfer decodes normally.
- Memory access: NONSEQ read at 0x0000_0104 with HRDATA_S0=0xDEADBEEF -> HSEL_S=4'b0001 in the address cycle and HRDATA=0xDEADBEEF in the next cycle.
- Back-to-back slaves with wait state: write 0x5000_0000, then read 0x5100_0004, with slave 1 holding HREADYOUT low for 2 cycles -> HREADY low for 2 cycles, dsel stays S1, then switches to S2, and slave 2 data is returned.
- Unmapped access (macro defined): NONSEQ at 0x6000_0000 -> cycle 1 HREADY=0/HRESP=1, cycle 2 HREADY=1/HRESP=1, then OKAY.
- Unmapped access (macro undefined): NONSEQ at 0x6000_0000 -> single cycle with HREADY=1, HRESP=0, HRDATA=0.
- Unmapped IDLE at 0x6000_0000 followed by a SEQ into S0 -> zero-wait OKAY, no ERROR, and S0 is selected.

Source files
------------

// File: rtl/ahb_lite_decoder_mux_if.sv
// ============================================================================
// ahb_lite_decoder_mux_if : master-side and slave-side AHB-Lite signals of the decoder/mux
// Revision: 1.0
// ============================================================================
`default_nettype none

interface ahb_lite_decoder_mux_if;
  logic [31:0] HADDR;
  logic [1:0]  HTRANS;
  logic [3:0]  HSEL_S;
  logic [3:0]  HREADYOUT_S;
  logic [3:0]  HRESP_S;
  logic [31:0] HRDATA_S0;
  logic [31:0] HRDATA_S1;
  logic [31:0] HRDATA_S2;
  logic [31:0] HRDATA_S3;
  logic        HREADY;
  logic        HRESP;
  logic [31:0] HRDATA;

  // Decoder/mux side
  modport slave (
    input  HADDR, HTRANS, HREADYOUT_S, HRESP_S,
    input  HRDATA_S0, HRDATA_S1, HRDATA_S2, HRDATA_S3,
    output HSEL_S, HREADY, HRESP, HRDATA
  );

  // Bus-master / slave-model side
  modport master (
    output HADDR, HTRANS, HREADYOUT_S, HRESP_S,
    output HRDATA_S0, HRDATA_S1, HRDATA_S2, HRDATA_S3,
    input  HSEL_S, HREADY, HRESP, HRDATA
  );
endinterface

`default_nettype wire

// File: rtl/ahb_lite_decoder_mux.sv
// ============================================================================
// ahb_lite_decoder_mux : AHB-Lite address decoder, response mux and default slave
// Define AHB_DECODER_ERR_EN to build the two-cycle ERROR default slave.
// Revision: 1.0
// ============================================================================
`default_nettype none

module ahb_lite_decoder_mux #(
  parameter logic [31:0] S0_BASE = 32'h0000_0000,
  parameter logic [31:0] S0_MASK = 32'hFFFF_8000,
  parameter logic [31:0] S1_BASE = 32'h5000_0000,
  parameter logic [31:0] S1_MASK = 32'hFF00_0000,
  parameter logic [31:0] S2_BASE = 32'h5100_0000,
  parameter logic [31:0] S2_MASK = 32'hFF00_0000,
  parameter logic [31:0] S3_BASE = 32'h5200_0000,
  parameter logic [31:0] S3_MASK = 32'hFF00_0000
) (
  input  logic                    HCLK,
  input  logic                    HRESET,
  ahb_lite_decoder_mux_if.slave   bus
);

  localparam logic [2:0] DSEL_S0  = 3'd0;
  localparam logic [2:0] DSEL_S1  = 3'd1;
  localparam logic [2:0] DSEL_S2  = 3'd2;
  localparam logic [2:0] DSEL_S3  = 3'd3;
  localparam logic [2:0] DSEL_DEF = 3'd4;

  logic [3:0]  w_hit;
  logic [3:0]  w_hsel;
  logic [2:0]  w_dec;
  logic        w_miss;
  logic [2:0]  r_dsel;
  logic        w_hready;
  logic        w_hresp;
  logic [31:0] w_hrdata;
  logic        w_def_ready;
  logic        w_def_resp;

  assign w_hit[0] = ((bus.HADDR & S0_MASK) == S0_BASE);
  assign w_hit[1] = ((bus.HADDR & S1_MASK) == S1_BASE);
  assign w_hit[2] = ((bus.HADDR & S2_MASK) == S2_BASE);
  assign w_hit[3] = ((bus.HADDR & S3_MASK) == S3_BASE);

  // Lowest index wins on overlapping windows, keeping HSEL_S one-hot.
  always_comb begin
    w_hsel = 4'b0000;
    w_dec  = DSEL_DEF;
    if (w_hit[0]) begin
      w_hsel = 4'b0001;
      w_dec  = DSEL_S0;
    end else if (w_hit[1]) begin
      w_hsel = 4'b0010;
      w_dec  = DSEL_S1;
    end else if (w_hit[2]) begin
      w_hsel = 4'b0100;
      w_dec  = DSEL_S2;
    end else if (w_hit[3]) begin
      w_hsel = 4'b1000;
      w_dec  = DSEL_S3;
    end
  end

  assign w_miss     = (w_hit == 4'b0000);
  assign bus.HSEL_S = w_hsel;

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      r_dsel <= DSEL_DEF;
    end else if (w_hready) begin
      r_dsel <= w_dec;
    end
  end

  always_comb begin
    w_hready = 1'b1;
    w_hresp  = 1'b0;
    w_hrdata = 32'h0000_0000;
    case (r_dsel)
      DSEL_S0: begin
        w_hready = bus.HREADYOUT_S[0];
        w_hresp  = bus.HRESP_S[0];
        w_hrdata = bus.HRDATA_S0;
      end
      DSEL_S1: begin
        w_hready = bus.HREADYOUT_S[1];
        w_hresp  = bus.HRESP_S[1];
        w_hrdata = bus.HRDATA_S1;
      end
      DSEL_S2: begin
        w_hready = bus.HREADYOUT_S[2];
        w_hresp  = bus.HRESP_S[2];
        w_hrdata = bus.HRDATA_S2;
      end
      DSEL_S3: begin
        w_hready = bus.HREADYOUT_S[3];
        w_hresp  = bus.HRESP_S[3];
        w_hrdata = bus.HRDATA_S3;
      end
      default: begin
        w_hready = w_def_ready;
        w_hresp  = w_def_resp;
      end
    endcase
  end

  assign bus.HREADY = w_hready;
  assign bus.HRESP  = w_hresp;
  assign bus.HRDATA = w_hrdata;

`ifdef AHB_DECODER_ERR_EN
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ERR1 = 2'd1,
    ST_ERR2 = 2'd2
  } def_state_t;

  def_state_t r_state;
  logic       r_def_ready;
  logic       r_def_resp;
  logic       w_err_req;

  assign w_err_req = w_hready & w_miss & bus.HTRANS[1];

  // Outputs are registered alongside the state so they change on the same edge.
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      r_state     <= ST_IDLE;
      r_def_ready <= 1'b1;
      r_def_resp  <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_err_req) begin
            r_state     <= ST_ERR1;
            r_def_ready <= 1'b0;
            r_def_resp  <= 1'b1;
          end
        end
        ST_ERR1: begin
          r_state     <= ST_ERR2;
          r_def_ready <= 1'b1;
          r_def_resp  <= 1'b1;
        end
        ST_ERR2: begin
          if (w_err_req) begin
            r_state     <= ST_ERR1;
            r_def_ready <= 1'b0;
            r_def_resp  <= 1'b1;
          end else begin
            r_state     <= ST_IDLE;
            r_def_ready <= 1'b1;
            r_def_resp  <= 1'b0;
          end
        end
        default: begin
          r_state     <= ST_IDLE;
          r_def_ready <= 1'b1;
          r_def_resp  <= 1'b0;
        end
      endcase
    end
  end

  assign w_def_ready = r_def_ready;
  assign w_def_resp  = r_def_resp;
`else
  logic w_unused_trans;

  assign w_unused_trans = &{1'b0, bus.HTRANS, w_miss};
  assign w_def_ready    = 1'b1;
  assign w_def_resp     = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_ahb_lite_decoder_mux.sv
// ============================================================================
// tb_ahb_lite_decoder_mux : randomized bench for the AHB-Lite decoder/mux
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_ahb_lite_decoder_mux;

`ifdef AHB_DECODER_ERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  localparam logic [31:0] BASES [4] = '{32'h0000_0000, 32'h5000_0000, 32'h5100_0000, 32'h5200_0000};
  localparam logic [31:0] MASKS [4] = '{32'hFFFF_8000, 32'hFF00_0000, 32'hFF00_0000, 32'hFF00_0000};

  logic HCLK = 1'b0;
  logic HRESET;
  always #5 HCLK = ~HCLK;

  logic [31:0] t_haddr;
  logic [1:0]  t_htrans;
  logic [3:0]  t_rdy;
  logic [3:0]  t_resp;
  logic [31:0] t_rdata [4];

  ahb_lite_decoder_mux_if bus ();

  assign bus.HADDR       = t_haddr;
  assign bus.HTRANS      = t_htrans;
  assign bus.HREADYOUT_S = t_rdy;
  assign bus.HRESP_S     = t_resp;
  assign bus.HRDATA_S0   = t_rdata[0];
  assign bus.HRDATA_S1   = t_rdata[1];
  assign bus.HRDATA_S2   = t_rdata[2];
  assign bus.HRDATA_S3   = t_rdata[3];

  ahb_lite_decoder_mux dut (
    .HCLK   (HCLK),
    .HRESET (HRESET),
    .bus    (bus.slave)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Reference state: who owns the data phase (4 = default slave) and how many
  // ERROR response cycles remain for the current default-slave transfer.
  int m_owner    = 4;
  int m_err_left = 0;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int ref_decode(input logic [31:0] a);
    for (int i = 0; i < 4; i++) begin
      if ((a & MASKS[i]) == BASES[i]) return i;
    end
    return 4;
  endfunction

  task automatic drive(input logic [31:0] addr, input logic [1:0] trans, input logic [3:0] rdy);
    t_haddr  = addr;
    t_htrans = trans;
    t_rdy    = rdy;
    t_resp   = 4'b0000;
  endtask

  // Called just after a falling edge with inputs applied; checks, then advances one cycle.
  task automatic step();
    int          dec;
    logic [3:0]  e_hsel;
    logic        e_rdy;
    logic        e_resp;
    logic [31:0] e_data;
    #1;
    dec    = ref_decode(t_haddr);
    e_hsel = (dec < 4) ? 4'(1 << dec) : 4'b0000;
    if (m_owner < 4) begin
      e_rdy  = t_rdy[m_owner];
      e_resp = t_resp[m_owner];
      e_data = t_rdata[m_owner];
    end else begin
      e_rdy  = (m_err_left != 2);
      e_resp = (m_err_left != 0);
      e_data = 32'h0;
    end
    check_val("hsel",   {28'h0, bus.HSEL_S}, {28'h0, e_hsel});
    check_val("hready", {31'h0, bus.HREADY}, {31'h0, e_rdy});
    check_val("hresp",  {31'h0, bus.HRESP},  {31'h0, e_resp});
    check_val("hrdata", bus.HRDATA, e_data);
    @(posedge HCLK);
    if (e_rdy) begin
      m_owner    = dec;
      m_err_left = (ERR_EN && dec == 4 && t_htrans[1]) ? 2 : 0;
    end else if (m_err_left == 2) begin
      m_err_left = 1;
    end
    @(negedge HCLK);
  endtask

  initial begin
    logic [31:0] a;
    HRESET = 1'b1;
    for (int i = 0; i < 4; i++) t_rdata[i] = $urandom;
    drive(32'h0000_0104, 2'b10, 4'b1111);

    // Reset state
    #2;
    check_val("rst_hready", {31'h0, bus.HREADY}, 32'h1);
    check_val("rst_hresp",  {31'h0, bus.HRESP},  32'h0);
    check_val("rst_hrdata", bus.HRDATA, 32'h0);
    check_val("rst_hsel",   {28'h0, bus.HSEL_S}, 32'h1);
    @(negedge HCLK);
    @(negedge HCLK);
    HRESET = 1'b0;

    // Memory access: NONSEQ read at 0x104
    t_rdata[0] = 32'hDEAD_BEEF;
    drive(32'h0000_0104, 2'b10, 4'b1111);
    #1 check_val("mem_hsel", {28'h0, bus.HSEL_S}, 32'h1);
    step();
    drive(32'h0000_0000, 2'b00, 4'b1111);
    #1 check_val("mem_rdata", bus.HRDATA, 32'hDEAD_BEEF);
    step();

    // Back-to-back S1 write (2 wait states) then S2 read
    t_rdata[2] = 32'hCAFE_0002;
    drive(32'h5000_0000, 2'b10, 4'b1111);
    step();
    drive(32'h5100_0004, 2'b10, 4'b1101);
    #1 check_val("b2b_wait1", {31'h0, bus.HREADY}, 32'h0);
    step();
    drive(32'h5100_0004, 2'b10, 4'b1101);
    #1 check_val("b2b_wait2", {31'h0, bus.HREADY}, 32'h0);
    step();
    drive(32'h5100_0004, 2'b10, 4'b1111);
    step();
    drive(32'h0000_0000, 2'b00, 4'b1111);
    #1 check_val("b2b_s2data", bus.HRDATA, 32'hCAFE_0002);
    step();

    // Unmapped NONSEQ
    drive(32'h6000_0000, 2'b10, 4'b1111);
    step();
    drive(32'h0000_0000, 2'b00, 4'b1111);
    #1;
    check_val("unm_c1_ready", {31'h0, bus.HREADY}, ERR_EN ? 32'h0 : 32'h1);
    check_val("unm_c1_resp",  {31'h0, bus.HRESP},  ERR_EN ? 32'h1 : 32'h0);
    check_val("unm_c1_rdata", bus.HRDATA, 32'h0);
    step();
    if (ERR_EN) begin
      #1;
      check_val("unm_c2_ready", {31'h0, bus.HREADY}, 32'h1);
      check_val("unm_c2_resp",  {31'h0, bus.HRESP},  32'h1);
      step();
    end
    step();

    // Unmapped IDLE then SEQ into S0
    drive(32'h6000_0000, 2'b00, 4'b1111);
    step();
    drive(32'h0000_0010, 2'b11, 4'b1111);
    #1;
    check_val("idle_ready", {31'h0, bus.HREADY}, 32'h1);
    check_val("idle_resp",  {31'h0, bus.HRESP},  32'h0);
    check_val("idle_hsel",  {28'h0, bus.HSEL_S}, 32'h1);
    step();
    drive(32'h0000_0000, 2'b00, 4'b1111);
    step();

    // Reset mid-read from S1 with S1 stalling
    drive(32'h5000_0010, 2'b10, 4'b1111);
    step();
    t_rdata[1] = 32'h1234_5678;
    drive(32'h0000_0000, 2'b00, 4'b1101);
    #1 check_val("pre_rst_ready", {31'h0, bus.HREADY}, 32'h0);
    #1 HRESET = 1'b1;
    #1;
    check_val("mid_rst_ready", {31'h0, bus.HREADY}, 32'h1);
    check_val("mid_rst_resp",  {31'h0, bus.HRESP},  32'h0);
    check_val("mid_rst_rdata", bus.HRDATA, 32'h0);
    m_owner    = 4;
    m_err_left = 0;
    @(negedge HCLK);
    HRESET = 1'b0;
    t_rdata[3] = 32'h0BAD_F00D;
    drive(32'h5200_0000, 2'b10, 4'b1111);
    step();
    drive(32'h0000_0000, 2'b00, 4'b1111);
    #1 check_val("post_rst_rdata", bus.HRDATA, 32'h0BAD_F00D);
    step();

    // Randomized traffic
    for (int n = 0; n < 1500; n++) begin
      case ($urandom_range(0, 5))
        0:       a = {17'h0, 15'($urandom)};
        1:       a = 32'h5000_0000 | {8'h0, 24'($urandom)};
        2:       a = 32'h5100_0000 | {8'h0, 24'($urandom)};
        3:       a = 32'h5200_0000 | {8'h0, 24'($urandom)};
        4:       a = 32'h6000_0000 | {8'h0, 24'($urandom)};
        default: a = $urandom;
      endcase
      t_haddr  = a;
      t_htrans = 2'($urandom_range(0, 3));
      for (int i = 0; i < 4; i++) begin
        t_rdy[i]   = ($urandom_range(0, 3) != 0);
        t_resp[i]  = ($urandom_range(0, 7) == 0);
        t_rdata[i] = $urandom;
      end
      step();
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
